alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 177 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//
// A three-state FSM (idle -> exec -> resp) accepts one operation, latches its operands,
// presents them to the shared ALU for one cycle, captures the result and holds it until
// the granted requester takes it.
//
// Ports:
//   clk_i, rst_n_i                  clock, asynchronous active-low reset
//   reqN_valid_i / reqN_ready_o     request handshake for requester N (N = 0, 1)
//   reqN_op1_i, reqN_op2_i          operands for requester N
//   reqN_operation_i                operation for requester N
//   rspN_valid_o / rspN_ready_i     response handshake for requester N
//   rspN_res_o                      result register (qualified by rspN_valid_o)
//   alu_op1_o, alu_op2_o            latched operands to the shared ALU
//   alu_operation_o                 latched operation to the shared ALU
//   alu_res_i                       combinational ALU result
//
// Configuration macro: ALU_ARB_ROUND_ROBIN_EN
//   defined   - round-robin between the requesters when both are valid
//   undefined - fixed priority, requester 0 wins

package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA
  } alu_operation_t;
endpackage

module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  // Requester 0
  input  logic                 req0_valid_i,
  output logic                 req0_ready_o,
  input  logic [DWIDTH-1:0]    req0_op1_i,
  input  logic [DWIDTH-1:0]    req0_op2_i,
  input  alu_operation_t       req0_operation_i,
  output logic                 rsp0_valid_o,
  input  logic                 rsp0_ready_i,
  output logic [DWIDTH-1:0]    rsp0_res_o,
  // Requester 1
  input  logic                 req1_valid_i,
  output logic                 req1_ready_o,
  input  logic [DWIDTH-1:0]    req1_op1_i,
  input  logic [DWIDTH-1:0]    req1_op2_i,
  input  alu_operation_t       req1_operation_i,
  output logic                 rsp1_valid_o,
  input  logic                 rsp1_ready_i,
  output logic [DWIDTH-1:0]    rsp1_res_o,
  // Shared ALU
  output logic [DWIDTH-1:0]    alu_op1_o,
  output logic [DWIDTH-1:0]    alu_op2_o,
  output alu_operation_t       alu_operation_o,
  input  logic [DWIDTH-1:0]    alu_res_i
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e             state_q, state_d;
  logic [DWIDTH-1:0]  op1_q, op1_d;
  logic [DWIDTH-1:0]  op2_q, op2_d;
  logic [DWIDTH-1:0]  res_q, res_d;
  alu_operation_t     operation_q, operation_d;
  logic               grant_q, grant_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic               last_q, last_d;
`endif

  logic any_valid;
  logic sel;        // requester picked this cycle (0 or 1)
  logic accept;
  logic rsp_taken;

  assign any_valid = req0_valid_i | req1_valid_i;

  always_comb begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
    // On contention, serve whoever did not win last time.
    if (req0_valid_i && req1_valid_i) begin
      sel = ~last_q;
    end else begin
      sel = ~req0_valid_i;
    end
`else
    sel = ~req0_valid_i;
`endif
  end

  // Gated with reset so a valid held during reset never sees a ready.
  assign accept       = (state_q == StIdle) & any_valid & rst_n_i;
  assign req0_ready_o = accept & ~sel;
  assign req1_ready_o = accept & sel;

  assign rsp_taken    = grant_q ? rsp1_ready_i : rsp0_ready_i;
  assign rsp0_valid_o = (state_q == StResp) & ~grant_q;
  assign rsp1_valid_o = (state_q == StResp) & grant_q;
  assign rsp0_res_o   = res_q;
  assign rsp1_res_o   = res_q;

  // ALU sees only latched values, never the live requester inputs.
  assign alu_op1_o       = op1_q;
  assign alu_op2_o       = op2_q;
  assign alu_operation_o = operation_q;

  always_comb begin
    state_d     = state_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    operation_d = operation_q;
    res_d       = res_q;
    grant_d     = grant_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          grant_d     = sel;
          op1_d       = sel ? req1_op1_i : req0_op1_i;
          op2_d       = sel ? req1_op2_i : req0_op2_i;
          operation_d = sel ? req1_operation_i : req0_operation_i;
`ifdef ALU_ARB_ROUND_ROBIN_EN
          last_d      = sel;
`endif
          state_d     = StExec;
        end
      end
      StExec: begin
        res_d   = alu_res_i;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_taken) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      op1_q       <= '0;
      op2_q       <= '0;
      res_q       <= '0;
      operation_q <= ALU_ADD;
      grant_q     <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      res_q       <= res_d;
      operation_q <= operation_d;
      grant_q     <= grant_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: a behavioural ALU closes the loop, a scoreboard queue holds
// the expected result of every accepted request and is checked on each response handshake.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned DW = 32;

  logic           clk_i = 1'b0;
  logic           rst_n = 1'b0;
  logic           req0_valid = 1'b0, req1_valid = 1'b0;
  logic [DW-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  alu_operation_t req0_op = ALU_ADD, req1_op = ALU_ADD;
  logic           rsp0_rdy = 1'b0, rsp1_rdy = 1'b0;
  logic           req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o;
  logic [DW-1:0]  rsp0_res_o, rsp1_res_o, alu_op1_o, alu_op2_o, alu_res;
  alu_operation_t alu_operation_o;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  typedef struct {
    int            id;
    logic [DW-1:0] res;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] alu_ref(alu_operation_t op, logic [DW-1:0] a,
                                            logic [DW-1:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: return {{(DW-1){1'b0}}, a < b};
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      default:  return '0;
    endcase
  endfunction

  assign alu_res = alu_ref(alu_operation_o, alu_op1_o, alu_op2_o);

  alu_arbiter #(.DWIDTH(DW)) u_dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n),
    .req0_valid_i     (req0_valid),
    .req0_ready_o     (req0_ready_o),
    .req0_op1_i       (req0_a),
    .req0_op2_i       (req0_b),
    .req0_operation_i (req0_op),
    .rsp0_valid_o     (rsp0_valid_o),
    .rsp0_ready_i     (rsp0_rdy),
    .rsp0_res_o       (rsp0_res_o),
    .req1_valid_i     (req1_valid),
    .req1_ready_o     (req1_ready_o),
    .req1_op1_i       (req1_a),
    .req1_op2_i       (req1_b),
    .req1_operation_i (req1_op),
    .rsp1_valid_o     (rsp1_valid_o),
    .rsp1_ready_i     (rsp1_rdy),
    .rsp1_res_o       (rsp1_res_o),
    .alu_op1_o        (alu_op1_o),
    .alu_op2_o        (alu_op2_o),
    .alu_operation_o  (alu_operation_o),
    .alu_res_i        (alu_res)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req(input int n, input logic v, input alu_operation_t op,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (n == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  // Scoreboard push on acceptance, pop/compare on response handshake, protocol checks.
  always @(negedge clk_i) begin
    if (rst_n) begin
      if (req0_valid && req0_ready_o) sb_q.push_back('{0, alu_ref(req0_op, req0_a, req0_b)});
      if (req1_valid && req1_ready_o) sb_q.push_back('{1, alu_ref(req1_op, req1_a, req1_b)});
      if ((rsp0_valid_o && rsp0_rdy) || (rsp1_valid_o && rsp1_rdy)) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected_rsp", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("sb_id", rsp1_valid_o ? 1 : 0, e.id);
          check_eq("sb_res", rsp1_valid_o ? rsp1_res_o : rsp0_res_o, e.res);
        end
      end
      check_eq("ready_onehot", req0_ready_o & req1_ready_o, 0);
      check_eq("ready_wo_valid", (req0_ready_o & ~req0_valid) | (req1_ready_o & ~req1_valid), 0);
      check_eq("rsp_valid_onehot", rsp0_valid_o & rsp1_valid_o, 0);
    end
  end

  // An in-flight operation is discarded by reset.
  always @(negedge rst_n) sb_q.delete();

  // Issue one operation, check grant, ALU drive, latency and result.
  task automatic run_op(input int n, input alu_operation_t op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] exp, input string tag);
    bit got;
    int lat;
    drive_req(n, 1'b1, op, a, b);
    if (n == 0) rsp0_rdy = 1'b1; else rsp1_rdy = 1'b1;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk_i);
      if ((n == 0) ? req0_ready_o : req1_ready_o) got = 1;
      else step();
    end
    check_eq({tag, "_grant"}, got, 1);
    step();
    // Operands change right after acceptance; the in-flight result must not follow.
    drive_req(n, 1'b0, op, '0, '0);
    check_eq({tag, "_alu_op1"}, alu_op1_o, a);
    check_eq({tag, "_alu_op2"}, alu_op2_o, b);
    lat = 1;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk_i);
      if ((n == 0) ? rsp0_valid_o : rsp1_valid_o) got = 1;
      else begin
        step();
        lat++;
      end
    end
    check_eq({tag, "_rsp"}, got, 1);
    check_eq({tag, "_latency"}, lat, 2);
    check_eq({tag, "_res"}, (n == 0) ? rsp0_res_o : rsp1_res_o, exp);
    check_eq({tag, "_other_rsp"}, (n == 0) ? rsp1_valid_o : rsp0_valid_o, 0);
    step();
  endtask

  initial begin
    int grants[$];
    int exp_g[3];

    // Reset with both requesters asserting valid.
    drive_req(0, 1'b1, ALU_SUB, 'h11, 'h22);
    drive_req(1, 1'b1, ALU_XOR, 'h33, 'h44);
    #3;
    check_eq("rst_ready0", req0_ready_o, 0);
    check_eq("rst_ready1", req1_ready_o, 0);
    check_eq("rst_rsp0_valid", rsp0_valid_o, 0);
    check_eq("rst_rsp1_valid", rsp1_valid_o, 0);
    check_eq("rst_alu_op1", alu_op1_o, 0);
    check_eq("rst_alu_op2", alu_op2_o, 0);
    check_eq("rst_alu_operation", alu_operation_o, ALU_ADD);
    check_eq("rst_rsp0_res", rsp0_res_o, 0);
    check_eq("rst_rsp1_res", rsp1_res_o, 0);
    drive_req(0, 1'b0, ALU_ADD, '0, '0);
    drive_req(1, 1'b0, ALU_ADD, '0, '0);
    step();
    rst_n = 1'b1;
    step();

    run_op(0, ALU_ADD, 5, 7, 12, "single_add");
    run_op(0, ALU_SLL, 1, 4, 16, "sll_inchange");
    run_op(1, ALU_SRA, 32'h8000_0000, 4, 32'hF800_0000, "req1_sra");

    // Contention: both requesters valid for three full operations.
    drive_req(0, 1'b1, ALU_SUB, 10, 3);
    drive_req(1, 1'b1, ALU_XOR, 'hF0, 'h0F);
    rsp0_rdy = 1'b1;
    rsp1_rdy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_i);
      if (req0_ready_o) grants.push_back(0);
      if (req1_ready_o) grants.push_back(1);
      if (rsp0_valid_o) check_eq("cont_rsp0_res", rsp0_res_o, 7);
      if (rsp1_valid_o) check_eq("cont_rsp1_res", rsp1_res_o, 'hFF);
      step();
    end
    drive_req(0, 1'b0, ALU_ADD, '0, '0);
    drive_req(1, 1'b0, ALU_ADD, '0, '0);
`ifdef ALU_ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0};
`else
    exp_g = '{0, 0, 0};
`endif
    check_eq("cont_num_grants", grants.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("cont_grant%0d", i), (i < grants.size()) ? grants[i] : 99, exp_g[i]);
    end
    step();

    // Backpressure on requester 1 while requester 0 waits.
    rsp1_rdy = 1'b0;
    drive_req(1, 1'b1, ALU_SLT, {DW{1'b1}}, 1);
    @(negedge clk_i);
    check_eq("bp_grant1", req1_ready_o, 1);
    step();
    drive_req(1, 1'b0, ALU_ADD, '0, '0);
    drive_req(0, 1'b1, ALU_ADD, 1, 1);
    @(negedge clk_i);
    check_eq("bp_exec_rsp1", rsp1_valid_o, 0);
    check_eq("bp_exec_ready0", req0_ready_o, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check_eq($sformatf("bp_hold_valid%0d", i), rsp1_valid_o, 1);
      check_eq($sformatf("bp_hold_res%0d", i), rsp1_res_o, 1);
      check_eq($sformatf("bp_no_grant%0d", i), req0_ready_o, 0);
      check_eq($sformatf("bp_no_rsp0_%0d", i), rsp0_valid_o, 0);
      step();
    end
    rsp1_rdy = 1'b1;
    drive_req(0, 1'b0, ALU_ADD, '0, '0);
    @(negedge clk_i);
    check_eq("bp_release_valid", rsp1_valid_o, 1);
    step();

    // Reset during EXEC discards the operation.
    drive_req(0, 1'b1, ALU_ADD, 3, 4);
    rsp0_rdy = 1'b1;
    @(negedge clk_i);
    check_eq("mr_grant", req0_ready_o, 1);
    step();
    drive_req(0, 1'b0, ALU_ADD, '0, '0);
    check_eq("mr_exec_op1", alu_op1_o, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mr_alu_op1", alu_op1_o, 0);
    check_eq("mr_alu_op2", alu_op2_o, 0);
    check_eq("mr_rsp0_valid", rsp0_valid_o, 0);
    check_eq("mr_rsp1_valid", rsp1_valid_o, 0);
    check_eq("mr_rsp0_res", rsp0_res_o, 0);
    check_eq("mr_rsp1_res", rsp1_res_o, 0);
    check_eq("mr_ready0", req0_ready_o, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check_eq($sformatf("mr_no_rsp%0d", i), rsp0_valid_o | rsp1_valid_o, 0);
      step();
    end
    run_op(0, ALU_OR, 'hA0, 'h0B, 'hAB, "post_reset");
    run_op(1, ALU_SUB, 3, 5, 32'hFFFF_FFFE, "post_reset1");

    check_eq("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
